// File: rtl/rr_merge_pkg.sv
// Shared types and defaults for the two-stream round-robin merger.
// Optional grant counters are enabled with RR_MERGE_STATS_EN.
package rr_merge_pkg;

    localparam int DEF_D_WIDTH    = 6;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int STAT_W         = 16;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_merge_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty never
// depend on the push/pop requests of the current cycle.
module sync_fifo
    import rr_merge_pkg::*;
#(
    parameter int W     = DEF_D_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] push_data,
    input  logic         push,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rr_merge.sv
// Merges streams A and B round-robin into one registered output.
// Define RR_MERGE_STATS_EN to add saturating per-stream grant counters.
module rr_merge
    import rr_merge_pkg::*;
#(
    parameter int D_WIDTH    = DEF_D_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] a_data,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [D_WIDTH-1:0] b_data,
    input  logic               b_valid,
    output logic               b_ready,
`ifdef RR_MERGE_STATS_EN
    output logic [STAT_W-1:0]  grant_cnt_a,
    output logic [STAT_W-1:0]  grant_cnt_b,
`endif
    output logic [D_WIDTH-1:0] rtl_data,
    output logic               rtl_valid
);

    logic [D_WIDTH-1:0] head_a;
    logic [D_WIDTH-1:0] head_b;
    logic               empty_a;
    logic               empty_b;
    logic               full_a;
    logic               full_b;
    logic               grant_a;
    logic               grant_b;
    grant_e             last_grant;

    assign a_ready = !full_a && !rst;
    assign b_ready = !full_b && !rst;

    sync_fifo #(
        .W     (D_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push_data (a_data),
        .push      (a_valid && a_ready),
        .pop       (grant_a),
        .head      (head_a),
        .empty     (empty_a),
        .full      (full_a)
    );

    sync_fifo #(
        .W     (D_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push_data (b_data),
        .push      (b_valid && b_ready),
        .pop       (grant_b),
        .head      (head_b),
        .empty     (empty_b),
        .full      (full_b)
    );

    // A wins unless B is waiting and A was served last.
    always_comb begin
        grant_a = !empty_a && (empty_b || last_grant == GRANT_B);
        grant_b = !empty_b && !grant_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtl_data   <= '0;
            rtl_valid  <= 1'b0;
            last_grant <= GRANT_B;
        end else begin
            rtl_valid <= grant_a || grant_b;
            if (grant_a) begin
                rtl_data   <= head_a;
                last_grant <= GRANT_A;
            end else if (grant_b) begin
                rtl_data   <= head_b;
                last_grant <= GRANT_B;
            end
        end
    end

`ifdef RR_MERGE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_a <= '0;
            grant_cnt_b <= '0;
        end else begin
            if (grant_a) begin
                grant_cnt_a <= sat_inc(grant_cnt_a);
            end
            if (grant_b) begin
                grant_cnt_b <= sat_inc(grant_cnt_b);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_merge.sv
// Directed and random stimulus for rr_merge against a queue-based
// model of the round-robin merge; honours RR_MERGE_STATS_EN.
module tb_rr_merge;

    localparam int DW    = 6;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] b_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [DW-1:0] rtl_data;
    logic          rtl_valid;
`ifdef RR_MERGE_STATS_EN
    logic [15:0]   grant_cnt_a;
    logic [15:0]   grant_cnt_b;
`endif

    always #5 clk = ~clk;

    rr_merge #(
        .D_WIDTH    (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b_data      (b_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
`ifdef RR_MERGE_STATS_EN
        .grant_cnt_a (grant_cnt_a),
        .grant_cnt_b (grant_cnt_b),
`endif
        .rtl_data    (rtl_data),
        .rtl_valid   (rtl_valid)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: two queues, whoever was served last yields a tie.
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];
    bit            last_was_a;
    logic [DW-1:0] exp_data;
    logic          exp_valid;
    int            cnt_a;
    int            cnt_b;
    bit            acc_a;
    bit            acc_b;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".valid"}, 32'(rtl_valid), 32'(exp_valid));
        chk({tag, ".data"}, 32'(rtl_data), 32'(exp_data));
        chk({tag, ".a_ready"}, 32'(a_ready), 32'(qa.size() < DEPTH));
        chk({tag, ".b_ready"}, 32'(b_ready), 32'(qb.size() < DEPTH));
`ifdef RR_MERGE_STATS_EN
        chk({tag, ".cnt_a"}, 32'(grant_cnt_a), cnt_a);
        chk({tag, ".cnt_b"}, 32'(grant_cnt_b), cnt_b);
`endif
    endtask

    task automatic step(input string tag, input bit av,
                        input logic [DW-1:0] ad, input bit bv,
                        input logic [DW-1:0] bd);
        bit pick_a;
        bit pick_b;
        @(negedge clk);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        acc_a   = av && (qa.size() < DEPTH);
        acc_b   = bv && (qb.size() < DEPTH);
        pick_a  = qa.size() > 0 && (qb.size() == 0 || !last_was_a);
        pick_b  = qb.size() > 0 && !pick_a;
        exp_valid = pick_a || pick_b;
        if (pick_a) begin
            exp_data   = qa.pop_front();
            last_was_a = 1'b1;
            if (cnt_a < 65535) cnt_a++;
        end else if (pick_b) begin
            exp_data   = qb.pop_front();
            last_was_a = 1'b0;
            if (cnt_b < 65535) cnt_b++;
        end
        if (acc_a) qa.push_back(ad);
        if (acc_b) qb.push_back(bd);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst     = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        qa.delete();
        qb.delete();
        last_was_a = 1'b0;
        exp_data   = '0;
        exp_valid  = 1'b0;
        cnt_a      = 0;
        cnt_b      = 0;
        chk({tag, ".rst_valid"}, 32'(rtl_valid), 0);
        chk({tag, ".rst_data"}, 32'(rtl_data), 0);
        chk({tag, ".rst_a_ready"}, 32'(a_ready), 0);
        chk({tag, ".rst_b_ready"}, 32'(b_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outputs({tag, ".post_rst"});
    endtask

    initial begin
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        bit            saw_full;

        do_reset("init");

        // A only, back-to-back 05,06,07
        step("a3_0", 1'b1, 6'h05, 1'b0, 6'h00);
        chk("a3_first_lat", 32'(rtl_valid), 0);
        step("a3_1", 1'b1, 6'h06, 1'b0, 6'h00);
        chk("a3_out05", 32'(rtl_data), 32'h05);
        step("a3_2", 1'b1, 6'h07, 1'b0, 6'h00);
        chk("a3_out06", 32'(rtl_data), 32'h06);
        step("a3_3", 1'b0, 6'h00, 1'b0, 6'h00);
        chk("a3_out07", 32'(rtl_data), 32'h07);
        for (int i = 0; i < 3; i++) step("a3_idle", 1'b0, '0, 1'b0, '0);

        // Both streams every cycle; A must lead after reset
        do_reset("alt");
        for (int i = 0; i < 8; i++) begin
            step("alt", 1'b1, 6'(8'h10 + i), 1'b1, 6'(8'h20 + i));
            if (i == 1) chk("alt_first_a", 32'(rtl_data), 32'h10);
            if (i == 2) chk("alt_then_b", 32'(rtl_data), 32'h20);
        end
        for (int i = 0; i < 12; i++) step("alt_drain", 1'b0, '0, 1'b0, '0);

        // Fill A while B competes for every other pop
        do_reset("fill");
        va = 6'h01;
        vb = 6'h21;
        saw_full = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step("fill", 1'b1, va, 1'b1, vb);
            if (acc_a) va = va + 6'd1;
            if (acc_b) vb = vb + 6'd1;
            if (!a_ready) saw_full = 1'b1;
        end
        chk("fill_a_full_seen", 32'(saw_full), 1);
        for (int i = 0; i < 12; i++) step("fill_drain", 1'b0, '0, 1'b0, '0);

        // Reset with samples queued
        step("rq0", 1'b1, 6'h31, 1'b1, 6'h01);
        step("rq1", 1'b1, 6'h32, 1'b1, 6'h02);
        step("rq2", 1'b1, 6'h33, 1'b0, 6'h00);
        do_reset("midrst");
        step("rq_new", 1'b1, 6'h3F, 1'b0, 6'h00);
        step("rq_out", 1'b0, '0, 1'b0, '0);
        chk("rq_3f", 32'(rtl_data), 32'h3F);
        for (int i = 0; i < 4; i++) step("rq_idle", 1'b0, '0, 1'b0, '0);

        // Pointer wrap: 10 samples through A at full rate
        do_reset("wrap");
        for (int i = 0; i < 10; i++) begin
            step("wrap", 1'b1, 6'(8'h08 + i), 1'b0, '0);
            if (i > 0) chk("wrap_contig", 32'(rtl_valid), 1);
        end
        step("wrap_last", 1'b0, '0, 1'b0, '0);
        chk("wrap_last_data", 32'(rtl_data), 32'h11);

        // Three A grants then two B grants
        do_reset("stats");
        for (int i = 0; i < 3; i++) step("st_a", 1'b1, 6'(i), 1'b0, '0);
        for (int i = 0; i < 2; i++) step("st_b", 1'b0, '0, 1'b1, 6'(i));
        for (int i = 0; i < 3; i++) step("st_idle", 1'b0, '0, 1'b0, '0);
        chk("st_model_a", 32'(cnt_a), 3);
        chk("st_model_b", 32'(cnt_b), 2);
`ifdef RR_MERGE_STATS_EN
        chk("st_cnt_a", 32'(grant_cnt_a), 3);
        chk("st_cnt_b", 32'(grant_cnt_b), 2);
`endif

        // Random traffic
        do_reset("rand");
        for (int i = 0; i < 400; i++) begin
            step("rand", 1'($urandom_range(0, 99) < 70), 6'($urandom),
                 1'($urandom_range(0, 99) < 60), 6'($urandom));
            if (i == 200) do_reset("rand_rst");
        end
        for (int i = 0; i < 12; i++) step("rand_drain", 1'b0, '0, 1'b0, '0);
        chk("rand_empty_a", 32'(qa.size()), 0);
        chk("rand_empty_b", 32'(qb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
